// File: rtl/button_ctrl.sv
// button_ctrl: synchronises, debounces and edge-detects the three board buttons
// and runs the CPU run/halt/restart FSM that drives nRst.
// Optional feature: define SINGLE_STEP_EN to add the PAUSE / single-step state.
module button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int RST_PULSE       = 16
) (
    input  logic       cpuClk,
    input  logic       rst,
    input  logic [2:0] button,
    output logic       nRst,
    output logic       halted,
    output logic [2:0] pressPulse,
    output logic       stepStall
);

    localparam int RCW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0]   RC_MAX = RCW'(RST_PULSE - 1);

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        RUN     = 2'd1,
        RESTART = 2'd2
`ifdef SINGLE_STEP_EN
        , PAUSE = 2'd3
`endif
    } state_e;

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       db_q, db_d;
    logic [2:0]       dbLast_q;
    logic [2:0]       pulse_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_e           state_q, state_d;
    logic [RCW-1:0]   rc_q, rc_d;
    logic             nRst_q, halted_q;

    // Two-flop synchroniser; buttons idle high (released)
    always_ff @(posedge cpuClk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it persists for DEBOUNCE_CYCLES samples
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state, and a one-cycle pulse the cycle after a 1->0 change
    always_ff @(posedge cpuClk or posedge rst) begin
        if (rst) begin
            db_q     <= 3'b111;
            dbLast_q <= 3'b111;
            pulse_q  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q     <= db_d;
            dbLast_q <= db_q;
            pulse_q  <= dbLast_q & ~db_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SINGLE_STEP_EN
    logic stepGap;
    logic stall_q;
`endif

    // Next state: halt press wins, then run/restart press, then step press
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
`ifdef SINGLE_STEP_EN
        stepGap = 1'b0;
`endif
        if (pulse_q[1]) begin
            state_d = HALT;
        end else begin
            case (state_q)
                HALT: begin
                    if (pulse_q[0]) state_d = RUN;
                end
                RUN: begin
                    if (pulse_q[0]) begin
                        state_d = RESTART;
                        rc_d    = '0;
                    end
`ifdef SINGLE_STEP_EN
                    else if (pulse_q[2]) begin
                        state_d = PAUSE;
                    end
`endif
                end
                RESTART: begin
                    if (pulse_q[0]) begin
                        rc_d = '0;
                    end else if (rc_q == RC_MAX) begin
                        state_d = RUN;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
`ifdef SINGLE_STEP_EN
                PAUSE: begin
                    if (pulse_q[0]) begin
                        state_d = RUN;
                    end else if (pulse_q[2]) begin
                        stepGap = 1'b1;
                    end
                end
`endif
                default: state_d = HALT;
            endcase
        end
    end

    // State register with outputs registered from the next state
    always_ff @(posedge cpuClk or posedge rst) begin
        if (rst) begin
            state_q  <= HALT;
            rc_q     <= '0;
            nRst_q   <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            rc_q     <= rc_d;
`ifdef SINGLE_STEP_EN
            nRst_q   <= (state_d == RUN) || (state_d == PAUSE);
`else
            nRst_q   <= (state_d == RUN);
`endif
            halted_q <= (state_d == HALT);
        end
    end

`ifdef SINGLE_STEP_EN
    // Stall held in PAUSE except for the single cycle of a step
    always_ff @(posedge cpuClk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= (state_d == PAUSE) && !stepGap;
        end
    end

    assign stepStall = stall_q;
`else
    assign stepStall = 1'b0;
`endif

    assign nRst       = nRst_q;
    assign halted     = halted_q;
    assign pressPulse = pulse_q;

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed and randomized checks of button_ctrl
// against a window-based reference model of debounce and the control FSM.
module tb_button_ctrl;

    localparam int DB = 4;
    localparam int RP = 3;
    localparam int S_HALT = 0, S_RUN = 1, S_RESTART = 2, S_PAUSE = 3;

    logic       cpuClk = 1'b0;
    logic       rst    = 1'b1;
    logic [2:0] button = 3'b111;
    logic       nRst, halted, stepStall;
    logic [2:0] pressPulse;

    int checks   = 0;
    int failures = 0;

    button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4),
        .RST_PULSE      (RP)
    ) dut (
        .cpuClk    (cpuClk),
        .rst       (rst),
        .button    (button),
        .nRst      (nRst),
        .halted    (halted),
        .pressPulse(pressPulse),
        .stepStall (stepStall)
    );

    always #5 cpuClk = ~cpuClk;

    // Reference model: pin samples per edge since reset, accepted level per edge
    logic [2:0] ph [$];
    logic [2:0] dbh [$];
    logic [2:0] m_pulse;
    int         m_state;
    int         m_rc;
    bit         m_step;

    function automatic logic [2:0] pin_at(input int k);
        if (k < 0) return 3'b111;
        return ph[k];
    endfunction

    function automatic logic [2:0] db_at(input int k);
        if (k < 0) return 3'b111;
        return dbh[k];
    endfunction

    task automatic model_reset();
        ph.delete();
        dbh.delete();
        m_pulse = 3'b000;
        m_state = S_HALT;
        m_rc    = 0;
        m_step  = 0;
    endtask

    // A level is accepted once the last DB synchronised samples all oppose it
    task automatic model_edge(input logic [2:0] b);
        int         e;
        logic [2:0] prev, nd, p, s;
        bit         all;
        ph.push_back(b);
        e    = ph.size() - 1;
        prev = db_at(e - 1);
        nd   = prev;
        for (int i = 0; i < 3; i++) begin
            all = 1;
            for (int k = 0; k < DB; k++) begin
                s = pin_at(e - 2 - k);
                if (s[i] == prev[i]) all = 0;
            end
            if (all) nd[i] = ~prev[i];
        end
        dbh.push_back(nd);
        p       = m_pulse;
        m_pulse = db_at(e - 2) & ~db_at(e - 1);
        m_step  = 0;
        if (p[1]) begin
            m_state = S_HALT;
        end else if (p[0]) begin
            case (m_state)
                S_HALT:    m_state = S_RUN;
                S_RUN:     begin m_state = S_RESTART; m_rc = 0; end
                S_RESTART: m_rc = 0;
                default:   m_state = S_RUN;
            endcase
        end else if (p[2]) begin
`ifdef SINGLE_STEP_EN
            if (m_state == S_RUN) m_state = S_PAUSE;
            else if (m_state == S_PAUSE) m_step = 1;
`endif
            if (m_state == S_RESTART) begin
                if (m_rc == RP - 1) m_state = S_RUN;
                else m_rc++;
            end
        end else if (m_state == S_RESTART) begin
            if (m_rc == RP - 1) m_state = S_RUN;
            else m_rc++;
        end
    endtask

    task automatic tick(input logic [2:0] b);
        button = b;
        @(posedge cpuClk);
        model_edge(b);
        @(negedge cpuClk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        button = 3'b111;
        repeat (3) @(posedge cpuClk);
        @(negedge cpuClk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        repeat (12) tick(3'b111);
    endtask

    task automatic press(input logic [2:0] lowMask);
        for (int j = 1; j <= 8; j++) tick(~lowMask);
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({nRst, halted, pressPulse, stepStall} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_vals got=%b want=010000",
                     {nRst, halted, pressPulse, stepStall});
        end
        for (int j = 0; j < 100; j++) begin
            tick(3'b111);
            checks++;
            if ({nRst, halted, pressPulse} !== 5'b01000) begin
                failures++;
                $display("FAIL idle cyc=%0d got=%b want=01000",
                         j, {nRst, halted, pressPulse});
            end
        end
    endtask

    task automatic test_press();
        for (int j = 1; j <= 12; j++) begin
            tick(j <= 8 ? 3'b110 : 3'b111);
            checks++;
            if (pressPulse !== (j == 7 ? 3'b001 : 3'b000) ||
                nRst !== (j >= 8) || halted !== (j < 8)) begin
                failures++;
                $display("FAIL press0 j=%0d got p=%b n=%b h=%b want p=%b n=%b h=%b",
                         j, pressPulse, nRst, halted,
                         (j == 7 ? 3'b001 : 3'b000), (j >= 8), (j < 8));
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        for (int j = 1; j <= 15; j++) begin
            tick(j <= 3 ? 3'b110 : 3'b111);
            checks++;
            if (pressPulse !== 3'b000 || nRst !== 1'b1 || halted !== 1'b0) begin
                failures++;
                $display("FAIL glitch j=%0d got p=%b n=%b h=%b want p=000 n=1 h=0",
                         j, pressPulse, nRst, halted);
            end
        end
    endtask

    task automatic test_restart();
        logic [2:0] b;
        for (int j = 1; j <= 14; j++) begin
            tick(j <= 8 ? 3'b110 : 3'b111);
            checks++;
            if (pressPulse[0] !== (j == 7) || halted !== 1'b0 ||
                nRst !== !(j >= 8 && j <= 10)) begin
                failures++;
                $display("FAIL restart j=%0d got p=%b n=%b h=%b want p0=%b n=%b h=0",
                         j, pressPulse, nRst, halted, (j == 7),
                         !(j >= 8 && j <= 10));
            end
        end
        settle();
        for (int j = 1; j <= 16; j++) begin
            b = {1'b1, !(j >= 3 && j <= 10), !(j <= 8)};
            tick(b);
            checks++;
            if (pressPulse[1] !== (j == 9) || nRst !== (j < 8) ||
                halted !== (j >= 10)) begin
                failures++;
                $display("FAIL restart_halt j=%0d got p=%b n=%b h=%b want p1=%b n=%b h=%b",
                         j, pressPulse, nRst, halted, (j == 9), (j < 8), (j >= 10));
            end
        end
        settle();
    endtask

    task automatic test_press2();
        press(3'b001);
        for (int j = 1; j <= 12; j++) begin
            tick(j <= 8 ? 3'b011 : 3'b111);
            checks++;
            if (pressPulse !== (j == 7 ? 3'b100 : 3'b000) || nRst !== 1'b1) begin
                failures++;
                $display("FAIL press2 j=%0d got p=%b n=%b want p=%b n=1",
                         j, pressPulse, nRst, (j == 7 ? 3'b100 : 3'b000));
            end
        end
        settle();
    endtask

    task automatic test_simul();
        for (int j = 1; j <= 12; j++) begin
            tick(j <= 8 ? 3'b100 : 3'b111);
            checks++;
            if (pressPulse !== (j == 7 ? 3'b011 : 3'b000) ||
                nRst !== (j < 8) || halted !== (j >= 8)) begin
                failures++;
                $display("FAIL simul j=%0d got p=%b n=%b h=%b want p=%b n=%b h=%b",
                         j, pressPulse, nRst, halted,
                         (j == 7 ? 3'b011 : 3'b000), (j < 8), (j >= 8));
            end
        end
        settle();
    endtask

    task automatic test_async_reset();
        press(3'b001);
        checks++;
        if (nRst !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_run got n=%b want n=1", nRst);
        end
        for (int j = 1; j <= 3; j++) tick(3'b110);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({nRst, halted, pressPulse, stepStall} !== 6'b010000) begin
            failures++;
            $display("FAIL async_rst got=%b want=010000",
                     {nRst, halted, pressPulse, stepStall});
        end
        repeat (2) @(posedge cpuClk);
        @(negedge cpuClk);
        rst = 1'b0;
        model_reset();
        for (int j = 1; j <= 10; j++) begin
            tick(3'b110);
            checks++;
            if (pressPulse[0] !== (j == 7) || nRst !== (j >= 8)) begin
                failures++;
                $display("FAIL requalify j=%0d got p=%b n=%b want p0=%b n=%b",
                         j, pressPulse, nRst, (j == 7), (j >= 8));
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic [2:0] cur;
        logic       en, eh, es;
        int         r;
        do_reset();
        cur = 3'b111;
        for (int j = 0; j < 3000; j++) begin
            r = $urandom_range(0, 15);
            if (r < 2) cur[$urandom_range(0, 2)] ^= 1'b1;
            tick(cur);
            en = (m_state == S_RUN) || (m_state == S_PAUSE);
            eh = (m_state == S_HALT);
            es = (m_state == S_PAUSE) && !m_step;
            checks++;
            if (nRst !== en || halted !== eh || pressPulse !== m_pulse ||
                stepStall !== es) begin
                failures++;
                $display("FAIL random cyc=%0d got n=%b h=%b p=%b s=%b want n=%b h=%b p=%b s=%b",
                         j, nRst, halted, pressPulse, stepStall, en, eh, m_pulse, es);
            end
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        do_reset();
        press(3'b001);
        for (int j = 1; j <= 8; j++) begin
            tick(3'b011);
            checks++;
            if (stepStall !== (j >= 8) || nRst !== 1'b1) begin
                failures++;
                $display("FAIL pause j=%0d got s=%b n=%b want s=%b n=1",
                         j, stepStall, nRst, (j >= 8));
            end
        end
        settle();
        for (int j = 1; j <= 10; j++) begin
            tick(j <= 8 ? 3'b011 : 3'b111);
            checks++;
            if (stepStall !== (j != 8) || nRst !== 1'b1) begin
                failures++;
                $display("FAIL step j=%0d got s=%b n=%b want s=%b n=1",
                         j, stepStall, nRst, (j != 8));
            end
        end
        settle();
        for (int j = 1; j <= 10; j++) begin
            tick(j <= 8 ? 3'b110 : 3'b111);
            checks++;
            if (stepStall !== (j < 8) || nRst !== 1'b1 || halted !== 1'b0) begin
                failures++;
                $display("FAIL unpause j=%0d got s=%b n=%b h=%b want s=%b n=1 h=0",
                         j, stepStall, nRst, halted, (j < 8));
            end
        end
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_restart();
        test_press2();
        test_simul();
        test_async_reset();
        test_random();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
- Conditions the three raw board push-buttons and produces the CPU run/reset control that the top level feeds into the CPU and MMU as nRst.
- Synchronises, debounces and edge-detects each button, then runs a small run/halt/restart FSM.
- Replaces the ad-hoc button latch at the top level; runs on cpuClk.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (min 2).
- CNT_W, 16: width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
- RST_PULSE, 16: cycles nRst is held low in RESTART (min 1).

Ports:
- cpuClk, input, 1: sole clock (CPU clock domain).
- rst, input, 1: asynchronous, active-high reset.
- button, input, 3: raw board buttons, active-low, asynchronous to cpuClk.
- nRst, output, 1: registered active-low reset to CPU/MMU.
- halted, output, 1: 1 while FSM is in HALT.
- pressPulse, output, 3: one-cycle pulse per debounced press (1->0 edge).
- stepStall, output, 1: stall request to CPU; tied 0 unless SINGLE_STEP_EN.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - nRst=0, halted=1, pressPulse=0, stepStall=0.
  - Synchroniser flops and debounced levels = 1 (released); counters = 0; state = HALT.
- Sync: 2-flop synchroniser per button. Latency from pin to synchronised level: 2 cycles.
- Debounce, per button i:
  - If sync[i]==db[i], cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1, db[i]<=sync[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and produces no change.
- Edge detect: pressPulse[i]=1 for exactly the cycle after db[i] goes 1->0. Release edges produce no pulse.
- Pin-to-pulse latency for a clean press: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states HALT, RUN, RESTART (plus PAUSE with the optional feature). Priority order within a cycle: press1 > press0 > press2.
  - HALT: nRst=0. press0 -> RUN. Other presses ignored.
  - RUN: nRst=1. press1 -> HALT. press0 -> RESTART (restart counter loaded to 0).
  - RESTART: nRst=0. Counter increments each cycle; at RST_PULSE-1 -> RUN.
    - press1 -> HALT (counter discarded).
    - press0 -> restart counter from 0.
- Simultaneous press0 and press1 in the same cycle -> HALT from any state.
- nRst and halted are registered from next-state: they change one cycle after the pulse cycle.
- rst asserted mid-debounce or mid-RESTART: everything returns to reset values immediately (asynchronously). A button held across rst deassertion must re-qualify through the full debounce before it is accepted.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds state PAUSE (nRst=1, stepStall=1).
  - RUN + press2 -> PAUSE.
  - PAUSE + press2: stepStall=0 for exactly one cycle, then 1 again (single step).
  - PAUSE + press0 -> RUN (stall released). PAUSE + press1 -> HALT.
  - stepStall is registered, reset 0.
- SINGLE_STEP_EN undefined:
  - No PAUSE state; stepStall constant 0.
  - press2 only raises pressPulse[2].

Test Plan:
- After rst release, all buttons high for 100 cycles (DEBOUNCE_CYCLES=4, RST_PULSE=3) -> nRst=0, halted=1, pressPulse=0 throughout.
- button[0] low for 8 cycles -> pressPulse[0] high exactly 1 cycle at 7 cycles after the falling pin edge; nRst=1, halted=0 on the next cycle.
- button[0] low for 3 cycles then high -> no pulse, counter returns to 0, state unchanged.
- In RUN, press button[0] -> nRst low for exactly 3 cycles, then 1. Press button[1] during RESTART -> HALT, nRst stays 0.
- button[0] and button[1] pressed on the same cycle from RUN -> one pulse on each, FSM goes to HALT, nRst=0; assert rst mid-debounce -> all outputs at reset values the same cycle.
- With SINGLE_STEP_EN: RUN, press2 -> stepStall=1. Press2 again -> stepStall=0 for exactly 1 cycle. Press0 -> stepStall=0, nRst=1.
